// File: rtl/apx_mul_result_checker.sv
// ----------------------------------------------------------------------------
// apx_mul_result_checker
//
// On-chip response checker for the configurable integer multiplier family.
// It watches the same operand pair (a, b) that the multiplier under test
// receives, delays it by DUT_LATENCY cycles so it lines up with the
// multiplier's result d, computes the exact signed product, and gathers error
// statistics over a programmed number of samples.
//
// Pipeline:  {in_valid,a,b} -> delay line (DUT_LATENCY) -> compare register
//            -> statistics / FSM.  Statistics therefore trail the aligned
//            sample by one clock.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        one-cycle pulse: clear statistics, latch num_samples, run
//   num_samples  samples per run (0 completes immediately)
//   in_valid     a/b carry a valid operand pair this cycle
//   a, b         operands as driven to the multiplier
//   d            multiplier result, DUT_LATENCY cycles after a/b
//   busy         high while a run is collecting samples
//   done         high once the programmed number of samples is collected
//   sample_cnt   samples compared in this run
//   mismatch_cnt samples whose d differed from the reference
//   max_err      largest absolute error seen
//   err_sum      saturating sum of absolute errors
//   err_sat      sticky: err_sum saturated during this run
// ----------------------------------------------------------------------------
module apx_mul_result_checker #(
  parameter int OP_BITWIDTH        = 28,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int DUT_LATENCY        = 1,
  parameter int CNT_W              = 16,
  parameter int ERR_ACC_W          = 48
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              num_samples,
  input  logic                          in_valid,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  input  logic [DATA_PATH_BITWIDTH-1:0] d,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              sample_cnt,
  output logic [CNT_W-1:0]              mismatch_cnt,
  output logic [DATA_PATH_BITWIDTH:0]   max_err,
  output logic [ERR_ACC_W-1:0]          err_sum,
  output logic                          err_sat
);

  localparam int DPW    = DATA_PATH_BITWIDTH;
  localparam int AW     = DPW + 1;
  // Product is formed wide enough for both the full product and the bus.
  localparam int PROD_W = (2 * OP_BITWIDTH > DPW) ? 2 * OP_BITWIDTH : DPW;
  // One carry bit above the wider of accumulator and error for saturation.
  localparam int SUM_W  = ((ERR_ACC_W > AW) ? ERR_ACC_W : AW) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] target_reg;

  // --------------------------------------------------------------------------
  // Operand delay line
  // --------------------------------------------------------------------------
  logic           v_d;
  logic [DPW-1:0] a_d;
  logic [DPW-1:0] b_d;

  generate
    if (DUT_LATENCY == 0) begin : g_no_delay
      assign v_d = in_valid;
      assign a_d = a;
      assign b_d = b;
    end else begin : g_delay
      logic           dl_v [DUT_LATENCY];
      logic [DPW-1:0] dl_a [DUT_LATENCY];
      logic [DPW-1:0] dl_b [DUT_LATENCY];

      // NOTE: only the valid bits need a reset; the operand storage is
      // qualified by them, so leaving it unreset keeps it plain flops/SRL.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DUT_LATENCY; i++) dl_v[i] <= 1'b0;
        end else begin
          dl_v[0] <= in_valid;
          for (int i = 1; i < DUT_LATENCY; i++) dl_v[i] <= dl_v[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dl_a[0] <= a;
        dl_b[0] <= b;
        for (int i = 1; i < DUT_LATENCY; i++) begin
          dl_a[i] <= dl_a[i-1];
          dl_b[i] <= dl_b[i-1];
        end
      end

      assign v_d = dl_v[DUT_LATENCY-1];
      assign a_d = dl_a[DUT_LATENCY-1];
      assign b_d = dl_b[DUT_LATENCY-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Reference product and absolute error
  // --------------------------------------------------------------------------
  logic signed [PROD_W-1:0] sa;
  logic signed [PROD_W-1:0] sb;
  logic signed [PROD_W-1:0] prod;
  logic        [DPW-1:0]    ref_val;
  logic        [AW-1:0]     diff;
  logic        [AW-1:0]     abs_err;

  // Operand bits above OP_BITWIDTH are don't-care; the sign comes from bit
  // OP_BITWIDTH-1 only.
  assign sa      = {{(PROD_W-OP_BITWIDTH){a_d[OP_BITWIDTH-1]}}, a_d[OP_BITWIDTH-1:0]};
  assign sb      = {{(PROD_W-OP_BITWIDTH){b_d[OP_BITWIDTH-1]}}, b_d[OP_BITWIDTH-1:0]};
  assign prod    = sa * sb;
  assign ref_val = prod[DPW-1:0];
  // One extra bit so signed d - signed ref cannot overflow.
  assign diff    = {d[DPW-1], d} - {ref_val[DPW-1], ref_val};
  assign abs_err = diff[AW-1] ? -diff : diff;

  // Ignored operand/product bits are gathered here so they are not flagged.
  logic unused_bits;
  assign unused_bits = ^{a_d, b_d, prod};

  // --------------------------------------------------------------------------
  // Compare register
  // --------------------------------------------------------------------------
  logic          cmp_valid;
  logic [AW-1:0] cmp_abs_err;

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid   <= 1'b0;
      cmp_abs_err <= '0;
    end else begin
      cmp_valid   <= v_d;
      cmp_abs_err <= abs_err;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics and control FSM
  // --------------------------------------------------------------------------
  logic [SUM_W-1:0] sum_ext;
  logic             sum_ovf;
  logic [CNT_W-1:0] cnt_next;

  assign sum_ext  = SUM_W'(err_sum) + SUM_W'(cmp_abs_err);
  assign sum_ovf  = |sum_ext[SUM_W-1:ERR_ACC_W];
  assign cnt_next = sample_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      target_reg   <= '0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      max_err      <= '0;
      err_sum      <= '0;
      err_sat      <= 1'b0;
    end else if (start) begin
      // Same action from every state; a sample arriving with start is dropped.
      target_reg   <= num_samples;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      max_err      <= '0;
      err_sum      <= '0;
      err_sat      <= 1'b0;
      state        <= (num_samples == '0) ? ST_DONE : ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (cmp_valid) begin
            sample_cnt <= cnt_next;
            if (cmp_abs_err != '0)     mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (cmp_abs_err > max_err) max_err      <= cmp_abs_err;
            if (sum_ovf) begin
              err_sum <= '1;
              err_sat <= 1'b1;
            end else begin
              err_sum <= sum_ext[ERR_ACC_W-1:0];
            end
            if (cnt_next == target_reg) state <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
